barrett_modmul_pipe: RTL
========================

// Module: barrett_modmul_pipe
// PURPOSE
//  Parametrised, pipelined Barrett reducer/modular multiplier for any odd modulus Q.
//  Computes x mod Q for a raw operand x (MODE 0) or for x = a*b (MODE 1).
//  Uses valid/ready streaming with full backpressure. Sits in the field-arithmetic datapath
//  and supersedes the fixed-Q combinational reducers.
//  Fully corrects the Barrett estimate (up to 3 subtractions). Single-subtract reducers are
//  wrong for large x.
// PARAMETERS
//  Q      743            modulus; odd; 3 <= Q < 2^K
//  K      $clog2(Q)      residue width; 2^(K-1) < Q <= 2^K
//  X_W    2*K            reducible operand width; any x < 2^X_W is legal
//  MU     2^(2K)/Q       Barrett constant, floor division, derived (1411 for Q=743); not overridable
//  TAG_W  4              sideband tag width, passed through unchanged
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input beat offered
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_mode    in   1      0: reduce in_x; 1: reduce in_a*in_b
//  in_x       in   X_W    raw operand, MODE 0 only
//  in_a       in   K      multiplicand, MODE 1; must be < Q
//  in_b       in   K      multiplier, MODE 1; must be < Q
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts when out_valid & out_ready
//  out_r      out  K      result, 0 <= out_r < Q
//  out_tag    out  TAG_W  tag of that beat
//  busy       out  1      OR of all stage valids
// BEHAVIOUR
//  Reset: all stage valids = 0, out_valid = 0, out_r = 0, out_tag = 0, busy = 0. in_ready = 1 after reset.
//  Pipeline: 4 register stages, each with a valid bit. All stages advance on one global enable:
//    en = !out_valid | out_ready; in_ready = en (combinational, no comb path from in_valid).
//  S1: x = mode ? a*b : in_x  (X_W bits); tag captured.
//  S2: qh = (x >> K) * MU;  t = qh >> K;  x forwarded.
//  S3: r = x - t*Q, computed mod 2^(K+2). Guaranteed 0 <= r < 4Q.
//  S4: out_r = r - j*Q, with j = largest value in {0,1,2,3} such that r >= j*Q.
//      Compare against Q, 2Q and 3Q in parallel; no iterative loop.
//  Latency: an accepted beat appears on out_valid exactly 4 cycles later if out_ready stays 1.
//  Throughput: 1 beat/cycle.
//  Order preserved; tag follows its beat.
//  Backpressure: out_valid & !out_ready freezes every stage (data and valid) and drops in_ready.
//    No beat is lost or duplicated. Bubbles are not squeezed out; simple global-stall design.
//  Simultaneous accept and emit in one cycle is legal: the pipe shifts by one.
//  Reset mid-operation: all in-flight beats are discarded; no partial output.
//  MODE 1 with a or b >= Q: the result is still (a*b) mod Q, because a*b < 2^X_W.
//  out_r/out_tag hold their last value while out_valid = 0. Not a checked value.
// STRUCTURE
//  barrett_pkg: function barrett_mu(Q,K); localparam widths K+2 and X_W; 3Q constant helper.
//  Sub-module barrett_final_correct (combinational, S4 logic), parametrised on Q and K.
//  Top module holds: stage registers, enable logic, multipliers.
// TESTING  (Q=743, K=10, MU=1411)
//  1. MODE 0: x = 0, 742, 743, 1486 -> out_r = 0, 742, 0, 0; each 4 cycles after accept.
//  2. MODE 0: x = 1048575 -> r = 1688 at S3 (2 subtractions needed) -> out_r = 202.
//  3. MODE 1: a = 742, b = 742 -> 1; a = 2, b = 400 -> 57; tags 0x3 and 0xA echoed in order.
//  4. Stream 16 random beats back to back with out_ready toggled 1,0,0,1,... ->
//     outputs match a golden (x % 743) model in order; none lost; in_ready = 0 exactly when stalled.
//  5. Fill the pipe (4 beats), hold out_ready = 0 for 5 cycles ->
//     out_valid stays 1 with a stable value; in_ready = 0; all 4 beats then drain in order.
//  6. Assert rst with 3 beats in flight -> next cycle out_valid = 0, busy = 0, out_r = 0;
//     no stale beat emerges afterwards.
//     Repeat tests 1-4 with Q=3329 (K=12) and Q=257 (K=9).

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared constants and helpers for the pipelined Barrett reducer.
// Widths derive from the modulus; MU is always computed, never passed in.
package barrett_pkg;

  localparam int Q_DEF = 743;
  localparam int TAG_W_DEF = 4;

  typedef enum logic {
    MODE_RAW = 1'b0,
    MODE_MUL = 1'b1
  } mode_e;

  function automatic longint unsigned barrett_mu(
    input int unsigned q,
    input int unsigned k
  );
    return (64'd1 << (2 * k)) / 64'(q);
  endfunction

  function automatic int res_w(input int k);
    return k + 2;
  endfunction

  function automatic int xw_w(input int k);
    return 2 * k;
  endfunction

  function automatic longint unsigned q_mult(
    input int unsigned q,
    input int unsigned j
  );
    return 64'(q) * 64'(j);
  endfunction

endpackage

// File: rtl/barrett_final_correct.sv
// Final Barrett correction: maps r in [0, 4Q) to r mod Q.
// Three parallel compares pick the subtraction count.
module barrett_final_correct
  import barrett_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int K = $clog2(Q)
) (
  input  logic [K+1:0] r,
  output logic [K-1:0] res
);

  localparam int R_W = res_w(K);
  localparam logic [R_W-1:0] Q1 = R_W'(q_mult(Q, 1));
  localparam logic [R_W-1:0] Q2 = R_W'(q_mult(Q, 2));
  localparam logic [R_W-1:0] Q3 = R_W'(q_mult(Q, 3));

  logic ge1;
  logic ge2;
  logic ge3;
  logic [R_W-1:0] d;

  assign ge1 = (r >= Q1);
  assign ge2 = (r >= Q2);
  assign ge3 = (r >= Q3);

  // Thermometer compares turned one-hot.
  always_comb begin
    d = r;
    unique case (1'b1)
      ge3:          d = r - Q3;
      (ge2 & !ge3): d = r - Q2;
      (ge1 & !ge2): d = r - Q1;
      (!ge1):       d = r;
    endcase
  end

  assign res = d[K-1:0];

endmodule

// File: rtl/barrett_modmul_pipe.sv
// Four-stage Barrett reducer / modular multiplier, valid/ready,
// single global stall enable driven by the output handshake.
module barrett_modmul_pipe
  import barrett_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int K = $clog2(Q),
  parameter int X_W = xw_w(K),
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [X_W-1:0]   in_x,
  input  logic [K-1:0]     in_a,
  input  logic [K-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int MU_W = K + 1;
  localparam int QH_W = X_W - K + MU_W;
  localparam int T_W = QH_W - K;
  localparam int TQ_W = T_W + K;
  localparam int R_W = res_w(K);
  localparam logic [MU_W-1:0] MU = MU_W'(barrett_mu(Q, K));

  logic             en;
  logic             v1, v2, v3, v4;
  logic [X_W-1:0]   s1_x;
  logic [R_W-1:0]   s2_xl;
  logic [T_W-1:0]   s2_t;
  logic [R_W-1:0]   s3_r;
  logic [K-1:0]     s4_r;
  logic [TAG_W-1:0] tg1, tg2, tg3, tg4;

  logic [2*K-1:0]   ab;
  logic [X_W-1:0]   x_in;
  logic [QH_W-1:0]  qh;
  logic [T_W-1:0]   t_next;
  logic [TQ_W-1:0]  tq;
  logic [R_W-1:0]   r_next;
  logic [K-1:0]     corr;

  assign en = !v4 | out_ready;
  assign in_ready = en;
  assign out_valid = v4;
  assign out_r = s4_r;
  assign out_tag = tg4;
  assign busy = v1 | v2 | v3 | v4;

  assign ab = (2*K)'(in_a) * (2*K)'(in_b);
  assign x_in = (mode_e'(in_mode) == MODE_MUL) ? X_W'(ab) : in_x;

  assign qh = QH_W'(s1_x[X_W-1:K]) * QH_W'(MU);
  assign t_next = T_W'(qh >> K);

  // Only the low K+2 bits matter: the true remainder is below 4Q.
  assign tq = TQ_W'(s2_t) * TQ_W'(Q);
  assign r_next = s2_xl - R_W'(tq);

  barrett_final_correct #(
    .Q(Q),
    .K(K)
  ) u_corr (
    .r  (s3_r),
    .res(corr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      v4    <= 1'b0;
      s1_x  <= '0;
      s2_xl <= '0;
      s2_t  <= '0;
      s3_r  <= '0;
      s4_r  <= '0;
      tg1   <= '0;
      tg2   <= '0;
      tg3   <= '0;
      tg4   <= '0;
    end else if (en) begin
      v1    <= in_valid;
      v2    <= v1;
      v3    <= v2;
      v4    <= v3;
      s1_x  <= x_in;
      s2_xl <= s1_x[R_W-1:0];
      s2_t  <= t_next;
      s3_r  <= r_next;
      s4_r  <= corr;
      tg1   <= in_tag;
      tg2   <= tg1;
      tg3   <= tg2;
      tg4   <= tg3;
    end
  end

endmodule
